// File: rtl/uart_mmio_responder.sv
// ============================================================================
// uart_mmio_responder : memory-mapped 8N1 UART with TXD/RXD/CON registers
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_mmio_responder #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WrData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] RdData,
  output logic        Hit,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [31:0]   TXD_ADDR  = BASE_ADDR;
  localparam logic [31:0]   RXD_ADDR  = BASE_ADDR + 32'd4;
  localparam logic [31:0]   CON_ADDR  = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // ---------------- bus decode ----------------
  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd;

  always_comb begin
    hit_txd = (Address == TXD_ADDR);
    hit_rxd = (Address == RXD_ADDR);
    hit_con = (Address == CON_ADDR);
    Hit     = hit_txd | hit_rxd | hit_con;
    wr_txd  = MemWrite & hit_txd;
    wr_con  = MemWrite & hit_con;
    rd_rxd  = MemRead  & hit_rxd;
  end

  logic unused_wrdata;
  assign unused_wrdata = ^{WrData[31:8], WrData[1:0]};

  // ---------------- state ----------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_idx_q,   tx_idx_d;
  logic [7:0]    txd_q,      txd_d;
  logic          uart_tx_q,  uart_tx_d;
  logic          tx_done_set;

  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_idx_q,   rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q,  rx_data_d;
  logic          rx_meta_q,  rx_sync_q;
  logic          rx_deliver, rx_stop_bad;

  logic tx_done_q,   tx_done_d;
  logic rx_valid_q,  rx_valid_d;
  logic overrun_q,   overrun_d;
  logic frame_err_q, frame_err_d;
  logic tx_irq_en_q, tx_irq_en_d;
  logic rx_irq_en_q, rx_irq_en_d;
  logic irq_q,       irq_d;
  logic tx_busy;

  assign tx_busy = (tx_state_q != S_IDLE);
  assign uart_tx = uart_tx_q;
  assign irq     = irq_q;

  // ---------------- read mux ----------------
  always_comb begin
    RdData = 32'd0;
    if (hit_txd) RdData = {24'd0, txd_q};
    if (hit_rxd) RdData = {24'd0, rx_data_q};
    if (hit_con) RdData = {25'd0, tx_irq_en_q, rx_irq_en_q, frame_err_q,
                           overrun_q, tx_done_q, rx_valid_q, tx_busy};
  end

  // ---------------- transmitter ----------------
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    txd_d       = txd_q;
    uart_tx_d   = uart_tx_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (wr_txd) begin
          txd_d      = WrData[7:0];
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          uart_tx_d  = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = 3'd0;
          tx_state_d = S_DATA;
          uart_tx_d  = txd_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = S_STOP;
            uart_tx_d  = 1'b1;
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            uart_tx_d = txd_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = S_IDLE;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  // The start bit is re-checked at half a bit so short glitches abort the frame.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_deliver  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_idx_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = '0;
          rx_state_d  = S_IDLE;
          rx_deliver  = 1'b1;
          rx_stop_bad = ~rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- flags, enables, interrupt ----------------
  // Sets are applied first so that a same-edge W1C clear always wins.
  always_comb begin
    rx_data_d   = rx_deliver ? rx_shift_q : rx_data_q;
    tx_done_d   = tx_done_q   | tx_done_set;
    frame_err_d = frame_err_q | (rx_deliver & rx_stop_bad);
    overrun_d   = overrun_q   | (rx_deliver & rx_valid_q & ~rd_rxd);
    rx_valid_d  = rx_deliver | (rx_valid_q & ~rd_rxd);
    tx_irq_en_d = tx_irq_en_q;
    rx_irq_en_d = rx_irq_en_q;
    if (wr_con) begin
      tx_irq_en_d = WrData[6];
      rx_irq_en_d = WrData[5];
      if (WrData[4]) frame_err_d = 1'b0;
      if (WrData[3]) overrun_d   = 1'b0;
      if (WrData[2]) tx_done_d   = 1'b0;
    end
    irq_d = (rx_valid_q & rx_irq_en_q) | (tx_done_q & tx_irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= 3'd0;
      txd_q       <= 8'd0;
      uart_tx_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      txd_q       <= txd_d;
      uart_tx_q   <= uart_tx_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      tx_done_q   <= tx_done_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_irq_en_q <= tx_irq_en_d;
      rx_irq_en_q <= rx_irq_en_d;
      irq_q       <= irq_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_responder.sv
// ============================================================================
// tb_uart_mmio_responder : directed self-checking bench, CLKS_PER_BIT = 4
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_mmio_responder;

  localparam int          CPB  = 4;
  localparam logic [31:0] TXD  = 32'h4000_0018;
  localparam logic [31:0] RXD  = 32'h4000_001C;
  localparam logic [31:0] CON  = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WrData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] RdData;
  logic        Hit;
  logic        uart_tx;
  logic        uart_rx;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_mmio_responder #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (TXD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Address (Address),
    .WrData  (WrData),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .RdData  (RdData),
    .Hit     (Hit),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] d);
    Address = addr;
    #1;
    d = RdData;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address  = addr;
    WrData   = data;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    Address  = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    Address = addr;
    MemRead = 1'b1;
    #1;
    d = RdData;
    tick();
    MemRead = 1'b0;
    Address = 32'd0;
  endtask

  // Called right after the TXD write edge; checks every cycle of the frame.
  task automatic tx_frame(input logic [7:0] b, input int wr_at, input logic [7:0] wr_byte);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    Address = CON;
    #1;
    for (int k = 0; k < 10 * CPB; k++) begin
      check_eq("tx_bit", {31'd0, uart_tx}, {31'd0, fr[k / CPB]});
      check_eq("tx_busy", {31'd0, RdData[0]}, 32'd1);
      if (k == wr_at) begin
        Address  = TXD;
        WrData   = {24'd0, wr_byte};
        MemWrite = 1'b1;
      end
      tick();
      MemWrite = 1'b0;
      Address  = CON;
      #1;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_rx_valid(input int budget);
    logic [31:0] d;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      peek(CON, d);
      if (d[1]) seen = 1'b1;
      else      tick();
    end
    check_eq("rx_valid_wait", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    reset = 1'b0; Address = 32'd0; WrData = 32'd0;
    MemRead = 1'b0; MemWrite = 1'b0; uart_rx = 1'b1;
    repeat (2) tick();

    // reset state and decode
    check_eq("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    peek(CON, d);
    check_eq("rst_con", d, 32'd0);
    peek(32'h4000_0014, d);
    check_eq("hit_below", {31'd0, Hit}, 32'd0);
    check_eq("rd_below", d, 32'd0);
    reset = 1'b1;
    tick();
    peek(CON, d);
    check_eq("hit_con", {31'd0, Hit}, 32'd1);
    peek(32'h4000_001A, d);
    check_eq("hit_misaligned", {31'd0, Hit}, 32'd0);
    peek(32'h4000_0024, d);
    check_eq("hit_above", {31'd0, Hit}, 32'd0);
    bus_write(32'h4000_0014, 32'h0000_00FF);
    check_eq("nohit_write_tx", {31'd0, uart_tx}, 32'd1);
    peek(TXD, d);
    check_eq("nohit_write_txd", d, 32'd0);

    // TX 0x55
    bus_write(TXD, 32'h55);
    tx_frame(8'h55, -1, 8'h00);
    peek(CON, d);
    check_eq("tx55_done", d, 32'h04);

    // tx interrupt: enable with tx_done already set
    bus_write(CON, 32'h40);
    check_eq("tx_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check_eq("tx_irq_on", {31'd0, irq}, 32'd1);
    bus_write(CON, 32'h04);
    tick();
    check_eq("tx_irq_off", {31'd0, irq}, 32'd0);
    peek(CON, d);
    check_eq("tx_done_w1c", d, 32'd0);

    // TXD write while busy is ignored
    bus_write(TXD, 32'hA3);
    tx_frame(8'hA3, 7, 8'hFF);
    peek(CON, d);
    check_eq("txa3_done", d, 32'h04);
    peek(TXD, d);
    check_eq("txd_kept", d, 32'hA3);
    repeat (8) tick();
    check_eq("no_second_frame", {31'd0, uart_tx}, 32'd1);
    peek(CON, d);
    check_eq("idle_after_ignore", d, 32'h04);
    bus_write(CON, 32'h04);

    // RX 0x3C with rx interrupt
    bus_write(CON, 32'h20);
    rx_send(8'h3C, 1'b1);
    wait_rx_valid(20);
    check_eq("rx_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check_eq("rx_irq_on", {31'd0, irq}, 32'd1);
    bus_read(CON, d);
    check_eq("rx3c_con", d, 32'h22);
    bus_read(RXD, d);
    check_eq("rx3c_data", d, 32'h3C);
    check_eq("rx_irq_hold", {31'd0, irq}, 32'd1);
    tick();
    check_eq("rx_irq_off", {31'd0, irq}, 32'd0);
    bus_read(CON, d);
    check_eq("rx_valid_cleared", d, 32'h20);
    bus_write(CON, 32'h00);

    // back-to-back frames -> overrun
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (4) tick();
    bus_read(CON, d);
    check_eq("overrun_con", d, 32'h0A);
    bus_read(RXD, d);
    check_eq("overrun_data", d, 32'h22);
    bus_write(CON, 32'h08);
    peek(CON, d);
    check_eq("overrun_w1c", d, 32'h00);

    // bad stop bit -> frame error, byte still delivered
    rx_send(8'h5A, 1'b0);
    repeat (10) tick();
    bus_read(CON, d);
    check_eq("frame_err_con", d, 32'h12);
    bus_read(RXD, d);
    check_eq("frame_err_data", d, 32'h5A);
    bus_write(CON, 32'h10);
    peek(CON, d);
    check_eq("frame_err_w1c", d, 32'h00);

    // one-cycle glitch is rejected
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (12) tick();
    peek(CON, d);
    check_eq("glitch_ignored", d, 32'h00);

    // reset mid-frame aborts TX at once
    bus_write(TXD, 32'h00);
    repeat (9) tick();
    check_eq("mid_frame_low", {31'd0, uart_tx}, 32'd0);
    peek(CON, d);
    check_eq("mid_frame_busy", d, 32'h01);
    reset = 1'b0;
    tick();
    check_eq("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
    peek(CON, d);
    check_eq("abort_con", d, 32'h00);
    reset = 1'b1;
    tick();
    check_eq("abort_stays_idle", {31'd0, uart_tx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
